// File: rtl/spi_cmd_if.sv
// spi_cmd_if: byte-stream (SPI_slave side) and register-bank signals of spi_cmd_ctrl.
// master = the command controller, slave = the SPI_slave / register bank environment.
interface spi_cmd_if #(
   parameter int AW = 7
);
   logic          ssel;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          tx_done;
   logic [7:0]    tx_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          busy;
   logic          err;

   modport master (
      input  ssel, rx_valid, rx_data, tx_done, rd_data,
      output tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, err
   );

   modport slave (
      output ssel, rx_valid, rx_data, tx_done, rd_data,
      input  tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, err
   );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: parses SSEL-framed {cmd, len, data...} transactions into register strobes.
// Build option AUTO_INC_EN: step the address after every data byte (else fixed FIFO-port address).
module spi_cmd_ctrl #(
   parameter int         AW    = 7,
   parameter int         LEN_W = 8,
   parameter logic [7:0] DUMMY = 8'hFF
) (
   input logic       clk,
   input logic       rst,
   spi_cmd_if.master bus
);
   // RREQ carries the rd_en strobe so that RFETCH sees rd_data one clock later.
   typedef enum logic [2:0] {IDLE, CMD, LEN, WDATA, RREQ, RFETCH, RDATA, DONE} state_t;

   state_t           state, state_nx;
   logic             rx_q, rx_prev, tx_q, tx_prev;
   logic             rx_edge, tx_edge;
   logic [7:0]       rx_byte;
   logic             rw, rw_nx;
   logic [AW-1:0]    addr, addr_nx, addr_step;
   logic [LEN_W-1:0] count, count_nx, len_field;
   logic [7:0]       tx_data_r, tx_data_nx;
   logic             wr_en_r, wr_en_nx;
   logic [AW-1:0]    wr_addr_r, wr_addr_nx;
   logic [7:0]       wr_data_r, wr_data_nx;
   logic             rd_en_r, rd_en_nx;
   logic             err_r, err_nx;

   assign rx_edge   = rx_q & ~rx_prev;
   assign tx_edge   = tx_q & ~tx_prev;
   assign len_field = rx_byte[LEN_W-1:0];

`ifdef AUTO_INC_EN
   assign addr_step = addr + AW'(1);
`else
   assign addr_step = addr;
`endif

   // NOTE: every sequential register uses <= so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rx_q      <= 1'b0;
         rx_prev   <= 1'b0;
         tx_q      <= 1'b0;
         tx_prev   <= 1'b0;
         rx_byte   <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         count     <= '0;
         tx_data_r <= DUMMY;
         wr_en_r   <= 1'b0;
         wr_addr_r <= '0;
         wr_data_r <= '0;
         rd_en_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         rx_q    <= bus.rx_valid;
         rx_prev <= rx_q;
         tx_q    <= bus.tx_done;
         tx_prev <= tx_q;
         if (bus.rx_valid && !rx_q) rx_byte <= bus.rx_data;
         state     <= state_nx;
         rw        <= rw_nx;
         addr      <= addr_nx;
         count     <= count_nx;
         tx_data_r <= tx_data_nx;
         wr_en_r   <= wr_en_nx;
         wr_addr_r <= wr_addr_nx;
         wr_data_r <= wr_data_nx;
         rd_en_r   <= rd_en_nx;
         err_r     <= err_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      rw_nx      = rw;
      addr_nx    = addr;
      count_nx   = count;
      tx_data_nx = tx_data_r;
      wr_en_nx   = 1'b0;
      wr_addr_nx = wr_addr_r;
      wr_data_nx = wr_data_r;
      rd_en_nx   = 1'b0;
      err_nx     = 1'b0;

      if (bus.ssel) begin
         // Deselect wins over any byte edge in the same cycle.
         state_nx   = IDLE;
         tx_data_nx = DUMMY;
         if (state inside {LEN, WDATA, RREQ, RFETCH, RDATA}) err_nx = 1'b1;
      end else begin
         case (state)
            IDLE: state_nx = CMD;
            CMD: if (rx_edge) begin
               rw_nx    = rx_byte[7];
               addr_nx  = AW'(rx_byte[6:0]);
               state_nx = LEN;
            end
            LEN: if (rx_edge) begin
               count_nx = len_field;
               if (len_field == '0) begin
                  state_nx = DONE;
               end else if (!rw) begin
                  state_nx = WDATA;
               end else begin
                  rd_en_nx = 1'b1;
                  state_nx = RREQ;
               end
            end
            WDATA: if (rx_edge) begin
               wr_en_nx   = 1'b1;
               wr_addr_nx = addr;
               wr_data_nx = rx_byte;
               addr_nx    = addr_step;
               count_nx   = count - LEN_W'(1);
               if (count == LEN_W'(1)) state_nx = DONE;
            end
            RREQ: state_nx = RFETCH;
            RFETCH: begin
               tx_data_nx = bus.rd_data;
               addr_nx    = addr_step;
               state_nx   = RDATA;
            end
            RDATA: if (tx_edge) begin
               count_nx = count - LEN_W'(1);
               if (count == LEN_W'(1)) begin
                  tx_data_nx = DUMMY;
                  state_nx   = DONE;
               end else begin
                  rd_en_nx = 1'b1;
                  state_nx = RREQ;
               end
            end
            DONE: if (rx_edge) err_nx = 1'b1;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign bus.tx_data = tx_data_r;
   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.wr_data = wr_data_r;
   assign bus.rd_en   = rd_en_r;
   assign bus.rd_addr = addr;
   assign bus.busy    = (state != IDLE);
   assign bus.err     = err_r;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed frames against spi_cmd_ctrl with a small register-bank responder.
// Expected write addresses follow the AUTO_INC_EN build option.
module tb_spi_cmd_ctrl;
`ifdef AUTO_INC_EN
   localparam int INC = 1;
`else
   localparam int INC = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] regs [0:127];
   logic [6:0] wr_log_addr [$];
   logic [7:0] wr_log_data [$];
   int         err_cnt  = 0;
   int         rd_cnt   = 0;
   int         both_cnt = 0;
   int         wb, eb, rb;

   spi_cmd_if #(.AW(7)) bus ();

   spi_cmd_ctrl #(.AW(7), .LEN_W(8), .DUMMY(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Register bank: read data valid exactly one clock after rd_en.
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= regs[bus.rd_addr];

   always @(negedge clk) begin
      if (bus.wr_en) begin
         wr_log_addr.push_back(bus.wr_addr);
         wr_log_data.push_back(bus.wr_data);
      end
      if (bus.err) err_cnt <= err_cnt + 1;
      if (bus.rd_en) rd_cnt <= rd_cnt + 1;
      if (bus.wr_en && bus.rd_en) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_begin();
      bus.ssel = 1'b0;
      tick(2);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick(2);
      bus.rx_valid = 1'b0;
      tick(4);
   endtask

   task automatic tx_pulse();
      bus.tx_done = 1'b1;
      tick(2);
      bus.tx_done = 1'b0;
      tick(4);
   endtask

   task automatic frame_end();
      bus.ssel = 1'b1;
      tick(3);
   endtask

   task automatic snap();
      wb = wr_log_addr.size();
      eb = err_cnt;
      rb = rd_cnt;
   endtask

   initial begin
      regs[7'h10] = 8'h11;
      regs[7'h11] = 8'h22;
      regs[7'h12] = 8'h33;
      rst          = 1'b1;
      bus.ssel     = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_done  = 1'b0;
      tick(2);
      check("rst_tx_data", bus.tx_data, 8'hFF);
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_rd_en", bus.rd_en, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_wr_addr", bus.wr_addr, 7'h00);
      rst = 1'b0;
      tick(2);

      // Write frame 05,03,A1,B2,C3.
      snap();
      frame_begin();
      check("w_busy", bus.busy, 1'b1);
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      frame_end();
      check("w_nwr", wr_log_addr.size() - wb, 3);
      check("w_a0", wr_log_addr[wb], 7'h05);
      check("w_a1", wr_log_addr[wb+1], 7'(5 + INC));
      check("w_a2", wr_log_addr[wb+2], 7'(5 + 2*INC));
      check("w_d0", wr_log_data[wb], 8'hA1);
      check("w_d1", wr_log_data[wb+1], 8'hB2);
      check("w_d2", wr_log_data[wb+2], 8'hC3);
      check("w_err", err_cnt - eb, 0);
      check("w_busy_end", bus.busy, 1'b0);

      // Read frame 90,02: first byte two clocks after the LEN edge acts.
      snap();
      frame_begin();
      send_byte(8'h90);
      bus.rx_data  = 8'h02;
      bus.rx_valid = 1'b1;
      tick(3);
      check("r_early", bus.tx_data, 8'hFF);
      tick(1);
      check("r_byte0", bus.tx_data, 8'h11);
      bus.rx_valid = 1'b0;
      tick(4);
      tx_pulse();
      check("r_byte1", bus.tx_data, (INC != 0) ? 8'h22 : 8'h11);
      tx_pulse();
      check("r_dummy", bus.tx_data, 8'hFF);
      check("r_busy_done", bus.busy, 1'b1);
      frame_end();
      check("r_nrd", rd_cnt - rb, 2);
      check("r_nwr", wr_log_addr.size() - wb, 0);
      check("r_err", err_cnt - eb, 0);

      // Address wrap 7F,02,AA,BB.
      snap();
      frame_begin();
      send_byte(8'h7F);
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      frame_end();
      check("wrap_nwr", wr_log_addr.size() - wb, 2);
      check("wrap_a0", wr_log_addr[wb], 7'h7F);
      check("wrap_a1", wr_log_addr[wb+1], 7'(7'h7F + INC));
      check("wrap_d1", wr_log_data[wb+1], 8'hBB);
      check("wrap_err", err_cnt - eb, 0);

      // Short frame 01,03,55 then deselect.
      snap();
      frame_begin();
      send_byte(8'h01);
      send_byte(8'h03);
      send_byte(8'h55);
      bus.ssel = 1'b1;
      tick(1);
      check("short_busy", bus.busy, 1'b0);
      check("short_err_pulse", bus.err, 1'b1);
      tick(1);
      check("short_err_clear", bus.err, 1'b0);
      tick(2);
      check("short_nwr", wr_log_addr.size() - wb, 1);
      check("short_d0", wr_log_data[wb], 8'h55);
      check("short_err", err_cnt - eb, 1);

      // Zero-length write then overrun byte 99.
      snap();
      frame_begin();
      send_byte(8'h02);
      send_byte(8'h00);
      bus.rx_data  = 8'h99;
      bus.rx_valid = 1'b1;
      tick(1);
      check("ovr_err_wait", bus.err, 1'b0);
      tick(1);
      check("ovr_err_pulse", bus.err, 1'b1);
      bus.rx_valid = 1'b0;
      tick(4);
      frame_end();
      check("ovr_nwr", wr_log_addr.size() - wb, 0);
      check("ovr_err", err_cnt - eb, 1);

      // Deselect in the same cycle as a data byte edge.
      snap();
      frame_begin();
      send_byte(8'h04);
      send_byte(8'h02);
      bus.rx_data  = 8'h33;
      bus.rx_valid = 1'b1;
      tick(1);
      bus.ssel = 1'b1;
      tick(1);
      check("race_wr_en", bus.wr_en, 1'b0);
      bus.rx_valid = 1'b0;
      tick(3);
      check("race_nwr", wr_log_addr.size() - wb, 0);
      check("race_err", err_cnt - eb, 1);

      // Async reset while a write strobe is in flight.
      snap();
      frame_begin();
      send_byte(8'h03);
      send_byte(8'h02);
      bus.rx_data  = 8'h77;
      bus.rx_valid = 1'b1;
      tick(2);
      check("rstw_wr_en_pre", bus.wr_en, 1'b1);
      rst = 1'b1;
      #1;
      check("rstw_wr_en", bus.wr_en, 1'b0);
      check("rstw_busy", bus.busy, 1'b0);
      check("rstw_tx", bus.tx_data, 8'hFF);
      check("rstw_wr_addr", bus.wr_addr, 7'h00);
      check("rstw_wr_data", bus.wr_data, 8'h00);
      bus.rx_valid = 1'b0;
      bus.ssel     = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      frame_begin();
      send_byte(8'h20);
      send_byte(8'h01);
      send_byte(8'h5A);
      frame_end();
      check("rstw_nwr", wr_log_addr.size() - wb, 1);
      check("rstw_a0", wr_log_addr[wb], 7'h20);
      check("rstw_d0", wr_log_data[wb], 8'h5A);
      check("rstw_err", err_cnt - eb, 0);

      check("no_wr_rd_overlap", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
